// File: rtl/ibex_pkg.sv
// Shared types for the LSU response path: access-size encoding and the
// response tracker state encoding.
package ibex_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_FIRST = 2'b01,
        WAIT_LAST  = 2'b10
    } lsu_resp_state_e;

endpackage

// File: rtl/ibex_load_align.sv
// Combinational load aligner: assembles the addressed word from the current
// beat (and the held first beat of a split access), then size-extends it.
module ibex_load_align
    import ibex_pkg::*;
(
    input  logic [31:0] hold_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  type_i,
    input  logic        sign_ext_i,
    input  logic        split_i,
    output logic [31:0] result_o
);

    logic [31:0] word_s;

    // Assemble the addressed word. A split half at offset 3 uses the same
    // byte splice as a split word; only its low 16 bits survive extension.
    always_comb begin
        word_s = rdata_i >> {offset_i, 3'b000};
        if (split_i) begin
            case (offset_i)
                2'd1:    word_s = {rdata_i[7:0],  hold_i[31:8]};
                2'd2:    word_s = {rdata_i[15:0], hold_i[31:16]};
                2'd3:    word_s = {rdata_i[23:0], hold_i[31:24]};
                default: word_s = rdata_i;
            endcase
        end else begin
            word_s = rdata_i >> {offset_i, 3'b000};
        end
    end

    // Size extension; the reserved encoding behaves as a word access.
    always_comb begin
        case (type_i)
            LSU_BYTE: result_o = {{24{sign_ext_i & word_s[7]}},  word_s[7:0]};
            LSU_HALF: result_o = {{16{sign_ext_i & word_s[15]}}, word_s[15:0]};
            default:  result_o = word_s;
        endcase
    end

endmodule

// File: rtl/ibex_load_resp_unit_chk.sv
// Protocol checker for ibex_load_resp_unit: data width legality, requests
// while not ready, and response beats with no operation outstanding.
module ibex_load_resp_unit_chk #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic rst_ni,
    input logic req_valid_i,
    input logic ready_i,
    input logic data_rvalid_i,
    input logic idle_i
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("ibex_load_resp_unit supports only DATA_WIDTH of 32");
    end

    a_req_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_valid_i && !ready_i))
        else $error("request issued while unit not ready; dropped");

    // Stale beats after a reset are tolerated, so this is advisory only.
    a_rvalid_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && idle_i))
        else $warning("response beat with no op outstanding; ignored");

endmodule

// File: rtl/ibex_load_resp_unit.sv
// LSU response tracker: follows the single outstanding (possibly split) op,
// aligns/extends load data and aggregates bus errors for writeback.
// Optional macro IBEX_LOAD_RESP_ERR_ADDR_EN adds the registered err_addr_o.
module ibex_load_resp_unit
    import ibex_pkg::*;
#(
    parameter bit          RVF_EN     = 1'b1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_ext_i,
    input  logic [1:0]            req_offset_i,
    input  logic                  req_split_i,
    input  logic                  req_fp_i,
    input  logic [31:0]           req_addr_i,
    output logic                  ready_o,
    output logic                  busy_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_err_i,
    output logic [DATA_WIDTH-1:0] rf_wdata_lsu_o,
    output logic                  rf_we_lsu_o,
    output logic                  fp_load_o,
    output logic                  lsu_resp_valid_o,
    output logic                  lsu_resp_err_o,
    output logic                  load_err_o,
    output logic                  store_err_o
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
    ,
    output logic [31:0]           err_addr_o
`endif
);

    lsu_resp_state_e state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  offset_q, offset_d;
    logic        split_q, split_d;
    logic        fp_q, fp_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] align_s;
    logic        final_s;
    logic        accept_s;

    ibex_load_align u_align (
        .hold_i     (hold_q),
        .rdata_i    (data_rdata_i),
        .offset_i   (offset_q),
        .type_i     (type_q),
        .sign_ext_i (sign_ext_q),
        .split_i    (split_q),
        .result_o   (align_s)
    );

    // Next-state, capture and zero-latency response generation.
    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        type_d           = type_q;
        sign_ext_d       = sign_ext_q;
        offset_d         = offset_q;
        split_d          = split_q;
        fp_d             = fp_q;
        addr_d           = addr_q;
        err_d            = err_q;
        hold_d           = hold_q;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_err_o   = 1'b0;
        rf_we_lsu_o      = 1'b0;
        load_err_o       = 1'b0;
        store_err_o      = 1'b0;

        final_s  = (state_q == WAIT_LAST) & data_rvalid_i;
        ready_o  = (state_q == IDLE) | final_s;
        busy_o   = (state_q != IDLE);
        accept_s = req_valid_i & ready_o;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
                    hold_d  = data_rdata_i;
                    err_d   = err_q | data_err_i;
                    state_d = WAIT_LAST;
                end else begin
                    state_d = WAIT_FIRST;
                end
            end
            WAIT_LAST: begin
                if (data_rvalid_i) begin
                    lsu_resp_valid_o = 1'b1;
                    lsu_resp_err_o   = err_q | data_err_i;
                    rf_we_lsu_o      = ~we_q & ~lsu_resp_err_o;
                    load_err_o       = ~we_q & lsu_resp_err_o;
                    store_err_o      = we_q & lsu_resp_err_o;
                    state_d          = IDLE;
                end else begin
                    state_d = WAIT_LAST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new op may be taken on the final beat of the previous one.
        if (accept_s) begin
            we_d       = req_we_i;
            type_d     = req_type_i;
            sign_ext_d = req_sign_ext_i;
            offset_d   = req_offset_i;
            split_d    = req_split_i;
            fp_d       = req_fp_i & RVF_EN;
            addr_d     = req_addr_i;
            err_d      = 1'b0;
            state_d    = req_split_i ? WAIT_FIRST : WAIT_LAST;
        end else begin
            err_d = err_d;
        end

        rf_wdata_lsu_o = rf_we_lsu_o ? align_s : 32'd0;
        fp_load_o      = lsu_resp_valid_o & fp_q & ~we_q & RVF_EN;
    end

    // State and captured op fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            type_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            offset_q   <= 2'b00;
            split_q    <= 1'b0;
            fp_q       <= 1'b0;
            addr_q     <= 32'd0;
            err_q      <= 1'b0;
            hold_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            type_q     <= type_d;
            sign_ext_q <= sign_ext_d;
            offset_q   <= offset_d;
            split_q    <= split_d;
            fp_q       <= fp_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
    logic [31:0] err_addr_q, err_addr_d;

    // An error first seen on the second split beat belongs to the next word.
    always_comb begin
        if (final_s && lsu_resp_err_o) begin
            if (err_q || !split_q) begin
                err_addr_d = addr_q;
            end else begin
                err_addr_d = {addr_q[31:2] + 30'd1, 2'b00};
            end
        end else begin
            err_addr_d = err_addr_q;
        end
    end

    // Error address holding register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= 32'd0;
        end else begin
            err_addr_q <= err_addr_d;
        end
    end

    assign err_addr_o = err_addr_q;
`else
    logic unused_addr_s;
    assign unused_addr_s = ^addr_q;
`endif

    ibex_load_resp_unit_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .ready_i       (ready_o),
        .data_rvalid_i (data_rvalid_i),
        .idle_i        (state_q == IDLE)
    );

endmodule

// File: tb/tb_ibex_load_resp_unit.sv
// Scoreboard bench for ibex_load_resp_unit: a byte-level memory model predicts
// each response; a negedge monitor pops and compares.
module tb_ibex_load_resp_unit;

    typedef struct packed {
        logic        we;
        logic [1:0]  typ;
        logic        sign;
        logic [1:0]  off;
        logic        split;
        logic        fp;
        logic [31:0] addr;
    } op_t;

    typedef struct packed {
        logic        err;
        logic        we;
        logic [31:0] wdata;
        logic        fp;
        logic        lerr;
        logic        serr;
        logic [31:0] err_addr;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i, req_we_i, req_sign_ext_i, req_split_i, req_fp_i;
    logic [1:0]  req_type_i, req_offset_i;
    logic [31:0] req_addr_i;
    logic        data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        ready_o, busy_o, rf_we_lsu_o, fp_load_o, lsu_resp_valid_o;
    logic        lsu_resp_err_o, load_err_o, store_err_o;
    logic [31:0] rf_wdata_lsu_o;
    logic        n_ready, n_busy, n_we, n_fp, n_valid, n_err, n_lerr, n_serr;
    logic [31:0] n_wdata;
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
    logic [31:0] err_addr_o, n_err_addr;
`endif

    ibex_load_resp_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
        .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i), .req_offset_i(req_offset_i),
        .req_split_i(req_split_i), .req_fp_i(req_fp_i), .req_addr_i(req_addr_i),
        .ready_o(ready_o), .busy_o(busy_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .rf_wdata_lsu_o(rf_wdata_lsu_o),
        .rf_we_lsu_o(rf_we_lsu_o), .fp_load_o(fp_load_o), .lsu_resp_valid_o(lsu_resp_valid_o),
        .lsu_resp_err_o(lsu_resp_err_o), .load_err_o(load_err_o), .store_err_o(store_err_o)
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
        , .err_addr_o(err_addr_o)
`endif
    );

    ibex_load_resp_unit #(.RVF_EN(1'b0)) dut_nofp (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
        .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i), .req_offset_i(req_offset_i),
        .req_split_i(req_split_i), .req_fp_i(req_fp_i), .req_addr_i(req_addr_i),
        .ready_o(n_ready), .busy_o(n_busy), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .rf_wdata_lsu_o(n_wdata),
        .rf_we_lsu_o(n_we), .fp_load_o(n_fp), .lsu_resp_valid_o(n_valid),
        .lsu_resp_err_o(n_err), .load_err_o(n_lerr), .store_err_o(n_serr)
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
        , .err_addr_o(n_err_addr)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic        exp_ready, exp_busy;
    logic        have_op;
    op_t         cur;
    int          beats_seen;
    logic [31:0] b1_data;
    logic        b1_err;
    logic [31:0] exp_err_addr;

    // Reference: view the beats as 8 consecutive memory bytes and read the
    // addressed little-endian value of the access size, then extend it.
    function automatic exp_t model(op_t op, logic [31:0] d0, logic e0, logic [31:0] d1, logic e1);
        exp_t        r;
        logic [7:0]  mem [8];
        logic [31:0] val;
        int          n;
        for (int i = 0; i < 4; i++) begin
            mem[i]   = op.split ? d0[8*i +: 8] : d1[8*i +: 8];
            mem[i+4] = op.split ? d1[8*i +: 8] : 8'h00;
        end
        n   = (op.typ == 2'd2) ? 1 : (op.typ == 2'd1) ? 2 : 4;
        val = 32'd0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = mem[int'(op.off) + i];
        if (n < 4 && op.sign && val[8*n-1]) begin
            for (int i = 8 * n; i < 32; i++) val[i] = 1'b1;
        end
        r.err      = (op.split & e0) | e1;
        r.we       = !op.we && !r.err;
        r.wdata    = r.we ? val : 32'd0;
        r.fp       = op.fp && !op.we;
        r.lerr     = !op.we && r.err;
        r.serr     = op.we && r.err;
        r.err_addr = (op.split && !e0) ? ((op.addr & ~32'd3) + 32'd4) : op.addr;
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  n;
        o.we   = ($urandom_range(0, 3) == 0);
        o.typ  = 2'($urandom_range(0, 3));
        o.sign = 1'($urandom_range(0, 1));
        o.off  = 2'($urandom_range(0, 3));
        o.fp   = 1'($urandom_range(0, 1));
        o.addr = {30'($urandom), o.off};
        n      = (o.typ == 2'd2) ? 1 : (o.typ == 2'd1) ? 2 : 4;
        o.split = (int'(o.off) + n > 4);
        return o;
    endfunction

    function automatic op_t mk_op(logic we, logic [1:0] typ, logic sign, logic split, logic fp, logic [31:0] addr);
        op_t o;
        o.we = we; o.typ = typ; o.sign = sign; o.off = addr[1:0];
        o.split = split; o.fp = fp; o.addr = addr;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs and advance the reference op tracker.
    task automatic step(input logic rv, input logic [31:0] rd, input logic er, input logic iss, input op_t op);
        int need;
        @(posedge clk_i); #1;
        exp_busy  = have_op;
        need      = cur.split ? 2 : 1;
        exp_ready = !have_op || (rv && beats_seen + 1 == need);
        if (have_op && rv) begin
            if (beats_seen + 1 == need) begin
                exp_q.push_back(model(cur, b1_data, b1_err, rd, er));
                have_op = 1'b0;
            end else begin
                b1_data    = rd;
                b1_err     = er;
                beats_seen = 1;
            end
        end
        data_rvalid_i  = rv;
        data_rdata_i   = rd;
        data_err_i     = er;
        req_valid_i    = iss && exp_ready;
        req_we_i       = op.we;
        req_type_i     = op.typ;
        req_sign_ext_i = op.sign;
        req_offset_i   = op.off;
        req_split_i    = op.split;
        req_fp_i       = op.fp;
        req_addr_i     = op.addr;
        if (iss && exp_ready) begin
            have_op = 1'b1; cur = op; beats_seen = 0; b1_data = 32'd0; b1_err = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        have_op = 1'b0; beats_seen = 0;
        exp_ready = 1'b1; exp_busy = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // Monitor: compare every cycle; pop the scoreboard on each response.
    initial begin
        exp_t e;
        exp_err_addr = 32'd0;
        forever begin
            @(negedge clk_i);
            chk("ready", 64'(ready_o), 64'(exp_ready));
            chk("busy", 64'(busy_o), 64'(exp_busy));
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
            if (!rst_ni) exp_err_addr = 32'd0;
            chk("err_addr", 64'(err_addr_o), 64'(exp_err_addr));
`endif
            if (lsu_resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(lsu_resp_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", 64'(lsu_resp_err_o), 64'(e.err));
                    chk("rf_we", 64'(rf_we_lsu_o), 64'(e.we));
                    chk("rf_wdata", 64'(rf_wdata_lsu_o), 64'(e.wdata));
                    chk("fp_load", 64'(fp_load_o), 64'(e.fp));
                    chk("load_err", 64'(load_err_o), 64'(e.lerr));
                    chk("store_err", 64'(store_err_o), 64'(e.serr));
                    chk("nofp_valid", 64'(n_valid), 64'(lsu_resp_valid_o));
                    chk("nofp_fp_load", 64'(n_fp), 64'(e.fp & 1'b0));
`ifdef IBEX_LOAD_RESP_ERR_ADDR_EN
                    if (e.err) exp_err_addr = e.err_addr;
`endif
                end
            end else begin
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    chk("missing_resp", 64'(lsu_resp_valid_o), 64'd1);
                end
                chk("quiet", {28'd0, rf_we_lsu_o, fp_load_o, lsu_resp_err_o, load_err_o, store_err_o, rf_wdata_lsu_o[30:0]},
                    64'(rf_wdata_lsu_o[31]) << 31);
            end
        end
    end

    initial begin
        op_t z;
        z = mk_op(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_type_i = 2'd0; req_sign_ext_i = 1'b0;
        req_offset_i = 2'd0; req_split_i = 1'b0; req_fp_i = 1'b0; req_addr_i = 32'd0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0; data_err_i = 1'b0;
        have_op = 1'b0; beats_seen = 0; cur = z; b1_data = 32'd0; b1_err = 1'b0;
        exp_ready = 1'b1; exp_busy = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Aligned signed byte at offset 2.
        step(1'b0, 32'd0, 1'b0, 1'b1, mk_op(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0102));
        step(1'b1, 32'h1280_3456, 1'b0, 1'b0, z);
        // Split word at offset 3.
        step(1'b0, 32'd0, 1'b0, 1'b1, mk_op(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_2003));
        step(1'b1, 32'hAABB_CCDD, 1'b0, 1'b0, z);
        step(1'b1, 32'h1122_3344, 1'b0, 1'b0, z);
        // Split half, error on the first beat only.
        step(1'b0, 32'd0, 1'b0, 1'b1, mk_op(1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0000_1003));
        step(1'b1, 32'h5566_7788, 1'b1, 1'b0, z);
        step(1'b1, 32'h99AA_BBCC, 1'b0, 1'b0, z);
        // Store error with a back-to-back FP load, then the FP load response.
        step(1'b0, 32'd0, 1'b0, 1'b1, mk_op(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_3000));
        step(1'b1, 32'h0, 1'b1, 1'b1, mk_op(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0000_4000));
        step(1'b1, 32'h3F80_0000, 1'b0, 1'b0, z);
        // Reset while the first beat of a split op is pending, then a stale beat.
        step(1'b0, 32'd0, 1'b0, 1'b1, mk_op(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_5001));
        step(1'b0, 32'd0, 1'b0, 1'b0, z);
        do_reset();
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, z);
        step(1'b0, 32'd0, 1'b0, 1'b0, z);

        for (int i = 0; i < 600; i++) begin
            step(have_op && ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), rand_op());
        end
        for (int k = 0; k < 4 && have_op; k++) step(1'b1, $urandom, 1'b0, 1'b0, z);
        step(1'b0, 32'd0, 1'b0, 1'b0, z);
        chk("drain_done", 64'(have_op), 64'd0);
        @(negedge clk_i); #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_load_resp_unit.md
Name: ibex_load_resp_unit

Overview:
Data-side response unit that sits between the data-memory bus response channel and the writeback stage. It tracks the single outstanding LSU operation, including misaligned two-beat accesses. It aligns and sign/zero-extends load data, merges split beats and aggregates bus errors. It produces the writeback-facing response signals: rf_wdata_lsu, rf_we_lsu, lsu_resp_valid, lsu_resp_err and the fp_load routing flag.

Parameters:
RVF_EN, 1'b1, when 0 req_fp_i is ignored and fp_load_o is tied to 0
DATA_WIDTH, 32, bus/register data width; only 32 is supported (elaboration assertion)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  first bus request of a new LSU op was granted this cycle
req_we_i  in  1  op is a store
req_type_i  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
req_sign_ext_i  in  1  sign-extend load result
req_offset_i  in  2  address bits [1:0]
req_split_i  in  1  misaligned; two response beats expected
req_fp_i  in  1  load targets the FP register file
req_addr_i  in  32  op byte address
ready_o  out  1  unit can accept req_valid_i this cycle
busy_o  out  1  op outstanding (state != IDLE)
data_rvalid_i  in  1  bus response beat valid
data_rdata_i  in  32  bus read data
data_err_i  in  1  bus error on this beat
rf_wdata_lsu_o  out  32  aligned/extended load data
rf_we_lsu_o  out  1  write load data to the register file
fp_load_o  out  1  current response is an FP load
lsu_resp_valid_o  out  1  final beat of the op received
lsu_resp_err_o  out  1  op completed with error
load_err_o  out  1  pulse: load completed with error
store_err_o  out  1  pulse: store completed with error

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. On reset: state IDLE, all captured op fields and the holding register clear to 0. All outputs read 0, except ready_o, which reads 1.
- States:
  - IDLE: no op outstanding.
  - WAIT_FIRST: split op, first beat pending.
  - WAIT_LAST: single-beat op, or second beat of a split op, pending.
- Accept condition: req_valid_i & ready_o.
  - ready_o = (state==IDLE) | (state==WAIT_LAST & data_rvalid_i). This gives back-to-back ops with no bubble.
  - On accept: capture we, type, sign_ext, offset, fp, addr and clear the sticky error. Next state is WAIT_FIRST if req_split_i, else WAIT_LAST.
  - req_valid_i while ready_o=0: ignored; assertion fires.
- WAIT_FIRST + data_rvalid_i: store data_rdata_i in hold_q, OR data_err_i into err_q, go to WAIT_LAST.
- WAIT_LAST + data_rvalid_i (final beat): combinational, zero latency.
  - lsu_resp_valid_o=1.
  - lsu_resp_err_o = err_q | data_err_i.
  - rf_we_lsu_o = ~we_q & ~lsu_resp_err_o.
  - load_err_o = ~we_q & lsu_resp_err_o; store_err_o = we_q & lsu_resp_err_o.
  - Next state: IDLE, or the new op's state if a request is accepted the same cycle.
- data_rvalid_i in IDLE: ignored, all outputs 0; assertion fires.
- Alignment (w = assembled word):
  - Aligned: w = rdata >> (8*offset).
  - Split word, offset 1/2/3: {rdata[7:0],hold[31:8]}, {rdata[15:0],hold[31:16]}, {rdata[23:0],hold[31:24]}.
  - Split half, offset 3: {16'b0, rdata[7:0], hold[31:24]}.
  - Extension: byte → w[7:0] sign- or zero-extended to 32; half → w[15:0] sign- or zero-extended; word → w.
- rf_wdata_lsu_o is valid only when rf_we_lsu_o=1; otherwise it is driven to 0.
- fp_load_o = lsu_resp_valid_o & fp_q & ~we_q & RVF_EN.
- Store responses never assert rf_we_lsu_o.
- Reset mid-op: the op is dropped; a later stale rvalid in IDLE is ignored.

Optional Feature:
- Macro: IBEX_LOAD_RESP_ERR_ADDR_EN.
- Defined: adds output err_addr_o [31:0], registered. It captures addr_q, or addr_q+4 with bits [1:0] cleared when the error arrived on the second split beat. Updated on the final beat when lsu_resp_err_o=1; holds otherwise; resets to 0.
- Undefined: the port and its register are absent; addr_q is captured but unused (lint tie-off).

Decomposition:
- ibex_pkg: lsu_type_e (LSU_WORD=2'b00, LSU_HALF=2'b01, LSU_BYTE=2'b10) and lsu_resp_state_e (IDLE, WAIT_FIRST, WAIT_LAST).
- One sub-module: ibex_load_align. Purely combinational: hold, rdata, offset, type, sign_ext, split → 32-bit result.
- The FSM, capture registers and error logic stay in the top.

Test Plan:
- Aligned signed byte: accept offset=2, type=byte, sign=1; next cycle rvalid, rdata=0x12_80_34_56 → rf_wdata_lsu_o=0xFFFFFF80, rf_we_lsu_o=1, lsu_resp_valid_o=1, same cycle.
- Split word, offset 3: beat1 rdata=0xAABBCCDD, beat2 rdata=0x11223344 → rf_wdata_lsu_o=0x223344AA on beat2 only; no response outputs on beat1.
- Split half error on beat1 only: data_err_i=1 then 0 → on beat2 lsu_resp_err_o=1, load_err_o=1, rf_we_lsu_o=0. With IBEX_LOAD_RESP_ERR_ADDR_EN, addr 0x1003 → err_addr_o=0x1003.
- Store with error: req_we_i=1, rvalid with data_err_i=1 → store_err_o=1, rf_we_lsu_o=0. Same cycle accept a new load: ready_o=1, state goes to WAIT_LAST with no idle cycle.
- FP load (RVF_EN=1, req_fp_i=1), word rdata=0x3F800000 → fp_load_o=1, rf_wdata_lsu_o=0x3F800000. With RVF_EN=0, fp_load_o=0.
- Reset asserted in WAIT_FIRST, then rvalid after release → all outputs 0, state IDLE, ready_o=1.
